// File: rtl/rnf_link_rxsnp_wrap.sv
// rnf_link_rxsnp_wrap
//   Receive side of the RXSNP link channel. Issues L-credits to the link
//   transmitter, buffers incoming snoop flits in arrival order, and presents
//   the oldest buffered flit to the snoop consumer with a valid/ready handshake.
//   Flits whose Opcode is SnpLCrdReturn (5'h00) hand a credit back without
//   being buffered.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   rxsnp_en       link active; 1 permits credit issue
//   rxsnpflitv     snoop flit valid from link
//   rxsnpflit      snoop flit from link
//   rxsnpflitpend  flit-pending hint (unused)
//   rxsnp_lcrdv    registered L-credit grant to transmitter
//   snp_valid      buffer head valid
//   snp_flit       buffer head flit
//   snp_ready      consumer accepts head
//   rxsnp_crd_out  credits outstanding at the transmitter
//   rxsnp_occ      buffer occupancy
//   rxsnp_err      sticky error: flit received with no credit outstanding
module rnf_link_rxsnp_wrap #(
   parameter  int SNP_FLIT_WIDTH  = 88,
   parameter  int RXSNP_BUF_DEPTH = 4,
   parameter  int OPCODE_LSB      = 50,
   localparam int CW              = $clog2(RXSNP_BUF_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rxsnp_en,
   input  logic                      rxsnpflitv,
   input  logic [SNP_FLIT_WIDTH-1:0] rxsnpflit,
   input  logic                      rxsnpflitpend,
   output logic                      rxsnp_lcrdv,
   output logic                      snp_valid,
   output logic [SNP_FLIT_WIDTH-1:0] snp_flit,
   input  logic                      snp_ready,
   output logic [CW-1:0]             rxsnp_crd_out,
   output logic [CW-1:0]             rxsnp_occ,
   output logic                      rxsnp_err
);

   localparam int            PW       = $clog2(RXSNP_BUF_DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(RXSNP_BUF_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(RXSNP_BUF_DEPTH);

   logic [SNP_FLIT_WIDTH-1:0] mem [RXSNP_BUF_DEPTH];
   logic [PW-1:0]             wr_ptr;
   logic [PW-1:0]             rd_ptr;
   logic [CW-1:0]             occ;
   logic [CW-1:0]             crd_out;
   logic                      lcrdv;
   logic                      err;

   logic [CW:0]               committed;
   logic                      issue;
   logic                      has_crd;
   logic                      is_return;
   logic                      consume;
   logic                      push;
   logic                      pop;
   logic                      unused_pend;

   assign unused_pend = rxsnpflitpend;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      // Buffer entries are either occupied or promised to the transmitter;
      // a new credit is only issued while some entry is neither.
      committed = {1'b0, occ} + {1'b0, crd_out};
      issue     = rxsnp_en & (committed < DEPTH_W);
      has_crd   = (crd_out != '0);
      is_return = (rxsnpflit[OPCODE_LSB +: 5] == 5'h00);
      consume   = rxsnpflitv & has_crd;
      // An outstanding credit guarantees a free entry, so push never overflows.
      push      = consume & ~is_return;
      pop       = (occ != '0) & snp_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ     <= '0;
         crd_out <= '0;
         lcrdv   <= 1'b0;
         err     <= 1'b0;
      end else begin
         lcrdv   <= issue;
         crd_out <= crd_out + CW'(issue) - CW'(consume);
         occ     <= occ + CW'(push) - CW'(pop);
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (rxsnpflitv & ~has_crd) err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rxsnpflit;
   end

   assign rxsnp_lcrdv   = lcrdv;
   assign snp_valid     = (occ != '0);
   assign snp_flit      = mem[rd_ptr];
   assign rxsnp_crd_out = crd_out;
   assign rxsnp_occ     = occ;
   assign rxsnp_err     = err;

endmodule

// File: tb/tb_rnf_link_rxsnp_wrap.sv
// tb_rnf_link_rxsnp_wrap
//   Self-checking bench for rnf_link_rxsnp_wrap. Directed scenarios check
//   fixed expectations; a randomized phase compares every cycle against a
//   transaction-level model (flit queue plus credit counter).
module tb_rnf_link_rxsnp_wrap;

   localparam int W  = 88;
   localparam int D  = 4;
   localparam int OL = 50;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rxsnp_en = 1'b0;
   logic          rxsnpflitv = 1'b0;
   logic [W-1:0]  rxsnpflit = '0;
   logic          rxsnpflitpend = 1'b0;
   logic          rxsnp_lcrdv;
   logic          snp_valid;
   logic [W-1:0]  snp_flit;
   logic          snp_ready = 1'b0;
   logic [CW-1:0] rxsnp_crd_out;
   logic [CW-1:0] rxsnp_occ;
   logic          rxsnp_err;

   int n_checks = 0;
   int n_fail   = 0;

   rnf_link_rxsnp_wrap #(
      .SNP_FLIT_WIDTH (W),
      .RXSNP_BUF_DEPTH(D),
      .OPCODE_LSB     (OL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rxsnp_en     (rxsnp_en),
      .rxsnpflitv   (rxsnpflitv),
      .rxsnpflit    (rxsnpflit),
      .rxsnpflitpend(rxsnpflitpend),
      .rxsnp_lcrdv  (rxsnp_lcrdv),
      .snp_valid    (snp_valid),
      .snp_flit     (snp_flit),
      .snp_ready    (snp_ready),
      .rxsnp_crd_out(rxsnp_crd_out),
      .rxsnp_occ    (rxsnp_occ),
      .rxsnp_err    (rxsnp_err)
   );

   always #5 clk = ~clk;

   // Reference model: queue of buffered flits and count of credits held by
   // the transmitter, updated once per rising edge from that cycle's inputs.
   logic [W-1:0] m_q[$];
   int           m_crd = 0;
   logic         m_err = 1'b0;
   logic         m_lcrdv = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_crd   = 0;
         m_err   = 1'b0;
         m_lcrdv = 1'b0;
      end else begin
         logic give, took;
         give = rxsnp_en && (m_q.size() + m_crd < D);
         took = rxsnpflitv && (m_crd > 0);
         if (rxsnpflitv && m_crd == 0) m_err = 1'b1;
         if (snp_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (took && rxsnpflit[OL +: 5] != 5'h00) m_q.push_back(rxsnpflit);
         m_crd   = m_crd + (give ? 1 : 0) - (took ? 1 : 0);
         m_lcrdv = give;
      end
   end

   function automatic logic [W-1:0] make_flit(input logic [4:0] op);
      logic [95:0]  r;
      logic [W-1:0] f;
      r = {$urandom, $urandom, $urandom};
      f = r[W-1:0];
      f[OL +: 5] = op;
      return f;
   endfunction

   // Advance one clock; inputs change and outputs are sampled at the negedge.
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [4:0] op, output logic [W-1:0] f);
      f = make_flit(op);
      rxsnpflit  = f;
      rxsnpflitv = 1'b1;
      cycle();
      rxsnpflitv = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rxsnp_en = 1'b1;
      repeat (2) cycle();
      n_checks++; if (rxsnp_lcrdv !== 1'b0) begin n_fail++; $display("FAIL reset_lcrdv got %b want 0", rxsnp_lcrdv); end
      n_checks++; if (snp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", snp_valid); end
      n_checks++; if (rxsnp_crd_out !== '0) begin n_fail++; $display("FAIL reset_crd got %0d want 0", rxsnp_crd_out); end
      n_checks++; if (rxsnp_occ !== '0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", rxsnp_occ); end
      n_checks++; if (rxsnp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", rxsnp_err); end
   endtask

   task automatic test_credit_init();
      logic [7:0] seen;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         seen[i] = rxsnp_lcrdv;
      end
      n_checks++; if (seen !== 8'b0000_1111) begin n_fail++; $display("FAIL init_lcrdv_pattern got %b want 00001111", seen); end
      n_checks++; if (rxsnp_crd_out !== CW'(4)) begin n_fail++; $display("FAIL init_crd got %0d want 4", rxsnp_crd_out); end
      n_checks++; if (snp_valid !== 1'b0) begin n_fail++; $display("FAIL init_valid got %b want 0", snp_valid); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp[4];
      int pulses;
      snp_ready = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         send(5'h01, exp[i]);
         if (rxsnp_lcrdv) pulses++;
      end
      n_checks++; if (rxsnp_occ !== CW'(4)) begin n_fail++; $display("FAIL fill_occ got %0d want 4", rxsnp_occ); end
      n_checks++; if (rxsnp_crd_out !== '0) begin n_fail++; $display("FAIL fill_crd got %0d want 0", rxsnp_crd_out); end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL fill_lcrdv got %0d pulses want 0", pulses); end
      snp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (snp_valid !== 1'b1 || snp_flit !== exp[i]) begin
            n_fail++;
            $display("FAIL drain_head%0d got v=%b %h want v=1 %h", i, snp_valid, snp_flit, exp[i]);
         end
         cycle();
         if (rxsnp_lcrdv) pulses++;
      end
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (rxsnp_lcrdv) pulses++;
      end
      snp_ready = 1'b0;
      n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL drain_lcrdv got %0d pulses want 4", pulses); end
      n_checks++; if (rxsnp_crd_out !== CW'(4)) begin n_fail++; $display("FAIL drain_crd got %0d want 4", rxsnp_crd_out); end
      n_checks++; if (rxsnp_occ !== '0) begin n_fail++; $display("FAIL drain_occ got %0d want 0", rxsnp_occ); end
   endtask

   task automatic test_credit_return();
      logic [W-1:0] f;
      int vseen, pulses;
      vseen = 0;
      pulses = 0;
      rxsnp_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(5'h00, f);
         if (snp_valid) vseen++;
         if (rxsnp_lcrdv) pulses++;
         n_checks++;
         if (rxsnp_crd_out !== CW'(3 - i)) begin
            n_fail++;
            $display("FAIL return_crd%0d got %0d want %0d", i, rxsnp_crd_out, 3 - i);
         end
      end
      repeat (2) begin
         cycle();
         if (rxsnp_lcrdv) pulses++;
      end
      n_checks++; if (rxsnp_occ !== '0) begin n_fail++; $display("FAIL return_occ got %0d want 0", rxsnp_occ); end
      n_checks++; if (vseen != 0) begin n_fail++; $display("FAIL return_valid got %0d cycles want 0", vseen); end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL return_lcrdv got %0d pulses want 0", pulses); end
   endtask

   task automatic test_drop();
      logic [W-1:0] f;
      send(5'h01, f);
      n_checks++; if (rxsnp_err !== 1'b1) begin n_fail++; $display("FAIL drop_err got %b want 1", rxsnp_err); end
      n_checks++; if (rxsnp_occ !== '0) begin n_fail++; $display("FAIL drop_occ got %0d want 0", rxsnp_occ); end
      n_checks++; if (rxsnp_crd_out !== '0) begin n_fail++; $display("FAIL drop_crd got %0d want 0", rxsnp_crd_out); end
      repeat (5) cycle();
      n_checks++; if (rxsnp_err !== 1'b1) begin n_fail++; $display("FAIL drop_err_held got %b want 1", rxsnp_err); end
   endtask

   task automatic test_push_pop();
      logic [W-1:0] f0, f1, f2;
      rst = 1'b1;
      rxsnp_en = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (6) cycle();
      snp_ready = 1'b0;
      send(5'h01, f0);
      send(5'h01, f1);
      n_checks++; if (rxsnp_occ !== CW'(2) || rxsnp_crd_out !== CW'(2)) begin n_fail++; $display("FAIL pp_setup got occ=%0d crd=%0d want 2/2", rxsnp_occ, rxsnp_crd_out); end
      n_checks++; if (rxsnp_err !== 1'b0) begin n_fail++; $display("FAIL pp_err_cleared got %b want 0", rxsnp_err); end
      snp_ready = 1'b1;
      send(5'h01, f2);
      snp_ready = 1'b0;
      n_checks++; if (rxsnp_occ !== CW'(2) || rxsnp_crd_out !== CW'(1)) begin n_fail++; $display("FAIL pp_same_cycle got occ=%0d crd=%0d want 2/1", rxsnp_occ, rxsnp_crd_out); end
      n_checks++; if (snp_flit !== f1) begin n_fail++; $display("FAIL pp_head got %h want %h", snp_flit, f1); end
      cycle();
      n_checks++; if (rxsnp_lcrdv !== 1'b1 || rxsnp_crd_out !== CW'(2)) begin n_fail++; $display("FAIL pp_reissue got lcrdv=%b crd=%0d want 1/2", rxsnp_lcrdv, rxsnp_crd_out); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] f;
      int pulses;
      send(5'h01, f);
      n_checks++; if (rxsnp_occ !== CW'(3) || rxsnp_crd_out !== CW'(1)) begin n_fail++; $display("FAIL mid_setup got occ=%0d crd=%0d want 3/1", rxsnp_occ, rxsnp_crd_out); end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({rxsnp_lcrdv, snp_valid, rxsnp_crd_out, rxsnp_occ, rxsnp_err} !== '0) begin
         n_fail++;
         $display("FAIL mid_async got lcrdv=%b v=%b crd=%0d occ=%0d err=%b want all 0",
                  rxsnp_lcrdv, snp_valid, rxsnp_crd_out, rxsnp_occ, rxsnp_err);
      end
      cycle();
      n_checks++;
      if ({rxsnp_lcrdv, snp_valid, rxsnp_crd_out, rxsnp_occ, rxsnp_err} !== '0) begin
         n_fail++;
         $display("FAIL mid_held got lcrdv=%b v=%b crd=%0d occ=%0d err=%b want all 0",
                  rxsnp_lcrdv, snp_valid, rxsnp_crd_out, rxsnp_occ, rxsnp_err);
      end
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (rxsnp_lcrdv) pulses++;
      end
      n_checks++; if (pulses != 4 || rxsnp_crd_out !== CW'(4)) begin n_fail++; $display("FAIL mid_fresh got pulses=%0d crd=%0d want 4/4", pulses, rxsnp_crd_out); end
      n_checks++; if (rxsnp_occ !== '0 || snp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_empty got occ=%0d v=%b want 0/0", rxsnp_occ, snp_valid); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         n_checks++; if (rxsnp_occ !== CW'(m_q.size())) begin n_fail++; $display("FAIL rnd_occ c%0d got %0d want %0d", c, rxsnp_occ, m_q.size()); end
         n_checks++; if (rxsnp_crd_out !== CW'(m_crd)) begin n_fail++; $display("FAIL rnd_crd c%0d got %0d want %0d", c, rxsnp_crd_out, m_crd); end
         n_checks++; if (rxsnp_lcrdv !== m_lcrdv) begin n_fail++; $display("FAIL rnd_lcrdv c%0d got %b want %b", c, rxsnp_lcrdv, m_lcrdv); end
         n_checks++; if (rxsnp_err !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d got %b want %b", c, rxsnp_err, m_err); end
         n_checks++; if (snp_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", c, snp_valid, m_q.size() != 0); end
         if (m_q.size() != 0) begin
            n_checks++; if (snp_flit !== m_q[0]) begin n_fail++; $display("FAIL rnd_head c%0d got %h want %h", c, snp_flit, m_q[0]); end
         end
         rxsnp_en      = ($urandom_range(0, 9) != 0);
         snp_ready     = ($urandom_range(0, 2) != 0);
         rxsnpflitpend = 1'($urandom);
         rxsnpflitv    = (m_crd > 0) && ($urandom_range(0, 2) != 0);
         rxsnpflit     = make_flit(($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom_range(1, 31)));
         cycle();
      end
      rxsnpflitv = 1'b0;
      snp_ready  = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_credit_init();
      test_back_to_back();
      test_credit_return();
      test_drop();
      test_push_pop();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
